icache_fetcher: RTL

ICACHE_FETCHER -- requirements
Module: icache_fetcher

---
 rtl/icache_fetcher.sv | 124 ++++++++++++
 1 files changed

// File: rtl/icache_fetcher.sv
// Direct-mapped instruction cache sitting between the core fetch port and the
// program-memory controller; one word per line, 1-cycle hits, blocking misses.
module icache_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_req_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_pc,
  output logic                             fetch_done,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count,
  output logic [1:0]                       dbg_state
);

  localparam int IDX   = $clog2(CACHE_LINES);
  localparam int TAG_W = PROGRAM_MEM_ADDR_BITS - IDX;

  // Handshakes: the core holds fetch_req_valid/fetch_pc until fetch_done; the
  // cache holds mem_read_valid/mem_read_address until mem_read_ready, and does
  // not return to IDLE until the controller has dropped mem_read_ready.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HIT_DONE  = 2'd1,
    MISS_WAIT = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t state;

  logic [CACHE_LINES-1:0]           line_valid;
  logic [TAG_W-1:0]                 tag_mem  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_mem [CACHE_LINES];

  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_en;

  assign req_idx  = fetch_pc[IDX-1:0];
  assign req_tag  = fetch_pc[PROGRAM_MEM_ADDR_BITS-1:IDX];
  // The outstanding miss address doubles as the latched pc for the fill.
  assign fill_idx = mem_read_address[IDX-1:0];
  assign fill_tag = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX];
  // A flush on the same edge as a lookup forces a miss.
  assign hit      = line_valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;
  assign fill_en  = (state == MISS_WAIT) && mem_read_ready;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      fetch_done       <= 1'b0;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      line_valid       <= '0;
      hit_count        <= 16'd0;
      miss_count       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req_valid) begin
            if (hit) begin
              instruction <= data_mem[req_idx];
              fetch_done  <= 1'b1;
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
              state       <= HIT_DONE;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= fetch_pc;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
              state            <= MISS_WAIT;
            end
          end
        end
        HIT_DONE: begin
          if (!fetch_req_valid) begin
            fetch_done <= 1'b0;
            state      <= IDLE;
          end
        end
        MISS_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid       <= 1'b0;
            instruction          <= mem_read_data;
            fetch_done           <= 1'b1;
            line_valid[fill_idx] <= 1'b1;
            state                <= RELEASE;
          end
        end
        RELEASE: begin
          if (!mem_read_ready && !fetch_req_valid) begin
            fetch_done <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Last assignment wins, so flush beats a concurrent fill's valid set.
      if (flush) line_valid <= '0;
    end
  end

  // Tag and data storage carry no reset; an invalid line's contents are never used.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_read_data;
    end
  end

endmodule
